// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the next-PC sequencer: state codes, instruction
// class codes, npc select codes and the interrupt vector.
package pc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_INT  = 3'd5,
    ST_RSV6 = 3'd6,
    ST_RSV7 = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_LW   = 3'd1,
    CLS_SW   = 3'd2,
    CLS_BEQ  = 3'd3,
    CLS_J    = 3'd4,
    CLS_JAL  = 3'd5,
    CLS_JR   = 3'd6,
    CLS_ERET = 3'd7
  } cls_e;

  localparam logic [2:0]  NPC_SEL_SEQ  = 3'd0;
  localparam logic [2:0]  NPC_SEL_BEQ  = 3'd1;
  localparam logic [2:0]  NPC_SEL_JMP  = 3'd2;
  localparam logic [2:0]  NPC_SEL_JR   = 3'd3;
  localparam logic [2:0]  NPC_SEL_INT  = 3'd4;
  localparam logic [2:0]  NPC_SEL_ERET = 3'd5;

  localparam logic [31:0] INT_VEC      = 32'h0000_4180;

  // npc select used in an instruction's final cycle when no interrupt is taken
  function automatic logic [2:0] npc_sel_for(input logic [2:0] cls);
    logic [2:0] sel;
    case (cls_e'(cls))
      CLS_R, CLS_LW, CLS_SW: sel = NPC_SEL_SEQ;
      CLS_BEQ:               sel = NPC_SEL_BEQ;
      CLS_J, CLS_JAL:        sel = NPC_SEL_JMP;
      CLS_JR:                sel = NPC_SEL_JR;
      CLS_ERET:              sel = NPC_SEL_ERET;
      default:               sel = NPC_SEL_SEQ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_mem_wdog.sv
// MEM-stage wait watchdog: counts waiting cycles and flags the last
// permitted cycle (count == MEM_TIMEOUT-1). Clear has priority over enable.
module pc_seq_ctrl_mem_wdog #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [TO_W-1:0] count_q;

  // wait counter: cleared on MEM exit, advances once per waiting cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {TO_W{1'b0}};
    end else if (clr_i) begin
      count_q <= {TO_W{1'b0}};
    end else if (en_i) begin
      count_q <= count_q + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign done_o = (count_q == TO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle next-PC sequencer. Steps each instruction through
// IF/ID/EX/MEM/WB, strobes the PC in the instruction's final cycle, and owns
// EPC/EXL for level interrupts taken at instruction boundaries.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cls,
  input  logic        irq,
  input  logic        ie,
  input  logic        mem_ready,
  input  logic [29:0] npc_in,
  output logic [2:0]  npc_sel,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        mem_req,
  output logic [29:0] epc,
  output logic        exl,
  output logic        bus_err,
  output logic [2:0]  state
);

  state_e      state_q, state_d;
  logic [29:0] epc_q, epc_d;
  logic        exl_q, exl_d;
  logic        wd_clr_s, wd_en_s, wd_done_s;
  logic        final_s;
  logic        take_s;

  // interrupt is only considered at a boundary and uses the pre-update exl
  assign take_s = irq & ie & ~exl_q;

  pc_seq_ctrl_mem_wdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_mem_wdog (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (wd_clr_s),
    .en_i   (wd_en_s),
    .done_o (wd_done_s)
  );

  // state, EPC and EXL registers; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IF;
      epc_q   <= 30'd0;
      exl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      exl_q   <= exl_d;
    end
  end

  // next-state and Moore/class output decode; boundary handling at the end
  always_comb begin
    state_d  = state_q;
    epc_d    = epc_q;
    exl_d    = exl_q;
    npc_sel  = NPC_SEL_SEQ;
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    mem_req  = 1'b0;
    bus_err  = 1'b0;
    wd_clr_s = 1'b1;
    wd_en_s  = 1'b0;
    final_s  = 1'b0;

    case (state_q)
      ST_IF: begin
        ir_we   = 1'b1;
        state_d = ST_ID;
      end
      ST_ID: begin
        case (cls_e'(cls))
          CLS_J, CLS_JR, CLS_ERET: final_s = 1'b1;
          CLS_JAL:                 state_d = ST_WB;
          default:                 state_d = ST_EX;
        endcase
      end
      ST_EX: begin
        case (cls_e'(cls))
          CLS_LW, CLS_SW: state_d = ST_MEM;
          CLS_BEQ:        final_s = 1'b1;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // completion beats a coincident timeout
          if (cls_e'(cls) == CLS_LW) begin
            state_d = ST_WB;
          end else begin
            final_s = 1'b1;
          end
        end else if (wd_done_s) begin
          // bus error: skip the instruction, no interrupt on this cycle
          bus_err = 1'b1;
          pc_we   = 1'b1;
          npc_sel = NPC_SEL_SEQ;
          state_d = ST_IF;
        end else begin
          wd_clr_s = 1'b0;
          wd_en_s  = 1'b1;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        final_s = 1'b1;
      end
      ST_INT: begin
        npc_sel = NPC_SEL_INT;
        pc_we   = 1'b1;
        exl_d   = 1'b1;
        state_d = ST_IF;
      end
      default: begin
        state_d = ST_IF;
      end
    endcase

    if (final_s) begin
      if (take_s) begin
        // hold the PC; EPC keeps the real resume target
        pc_we   = 1'b0;
        npc_sel = NPC_SEL_SEQ;
        epc_d   = npc_in;
        state_d = ST_INT;
      end else begin
        pc_we   = 1'b1;
        npc_sel = npc_sel_for(cls);
        state_d = ST_IF;
        if (cls_e'(cls) == CLS_ERET) begin
          exl_d = 1'b0;
        end else begin
          exl_d = exl_q;
        end
      end
    end else begin
      epc_d = epc_d;
    end
  end

  assign epc   = epc_q;
  assign exl   = exl_q;
  assign state = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: a path-table reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pc_seq_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cls = 3'd0;
  logic        irq = 1'b0;
  logic        ie = 1'b0;
  logic        mem_ready = 1'b0;
  logic [29:0] npc_in = 30'd0;
  logic [2:0]  npc_sel;
  logic        pc_we, ir_we, reg_we, mem_req, exl, bus_err;
  logic [29:0] epc;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  pc_seq_ctrl #(.MEM_TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .cls(cls), .irq(irq), .ie(ie),
    .mem_ready(mem_ready), .npc_in(npc_in), .npc_sel(npc_sel),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_req(mem_req),
    .epc(epc), .exl(exl), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: state sequence per class (0 IF,1 ID,2 EX,3 MEM,4 WB), its
  // length, and the npc select applied at the final step.
  int plen [8] = '{4, 5, 4, 3, 2, 3, 2, 2};
  int ptab [8][5] = '{'{0,1,2,4,0}, '{0,1,2,3,4}, '{0,1,2,3,0}, '{0,1,2,0,0},
                      '{0,1,0,0,0}, '{0,1,4,0,0}, '{0,1,0,0,0}, '{0,1,0,0,0}};
  int selmap [8] = '{0, 0, 0, 1, 2, 2, 3, 5};

  bit          m_int, n_int;
  int          m_pos, n_pos, m_wait, n_wait;
  logic [29:0] m_epc, n_epc;
  bit          m_exl, n_exl;
  int          cur, e_state, e_sel;
  bit          e_pcwe, e_ir, e_reg, e_mreq, e_berr, fin;
  bit          slow;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model one step.
  always @(negedge clk) begin
    if (!rst) begin
      m_int = 1'b0; m_pos = 0; m_wait = 0; m_epc = 30'd0; m_exl = 1'b0;
    end
    chk("m_epc", 32'(epc), 32'(m_epc));
    chk("m_exl", 32'(exl), 32'(m_exl));
    n_int = m_int; n_pos = m_pos; n_wait = m_wait; n_epc = m_epc; n_exl = m_exl;
    e_sel = 0; e_pcwe = 0; e_ir = 0; e_reg = 0; e_mreq = 0; e_berr = 0;
    if (m_int) begin
      e_state = 5; e_sel = 4; e_pcwe = 1;
      n_int = 0; n_exl = 1; n_pos = 0;
    end else begin
      cur = (m_pos == 0) ? 0 : ptab[cls][m_pos];
      e_state = cur;
      e_ir = (cur == 0); e_reg = (cur == 4); e_mreq = (cur == 3);
      fin = (m_pos == plen[cls] - 1);
      if (cur == 3 && !mem_ready) begin
        if (m_wait == TO - 1) begin
          e_berr = 1; e_pcwe = 1; n_pos = 0; n_wait = 0;
        end else begin
          n_wait = m_wait + 1;
        end
      end else if (fin) begin
        n_pos = 0; n_wait = 0;
        if (irq && ie && !m_exl) begin
          n_epc = npc_in; n_int = 1;
        end else begin
          e_pcwe = 1; e_sel = selmap[cls];
          if (cls == 3'd7) n_exl = 0;
        end
      end else begin
        n_pos = m_pos + 1; n_wait = 0;
      end
    end
    chk("m_state",   32'(state),   32'(e_state));
    chk("m_npc_sel", 32'(npc_sel), 32'(e_sel));
    chk("m_pc_we",   32'(pc_we),   32'(e_pcwe));
    chk("m_ir_we",   32'(ir_we),   32'(e_ir));
    chk("m_reg_we",  32'(reg_we),  32'(e_reg));
    chk("m_mem_req", 32'(mem_req), 32'(e_mreq));
    chk("m_bus_err", 32'(bus_err), 32'(e_berr));
    if (rst) begin
      m_int = n_int; m_pos = n_pos; m_wait = n_wait; m_epc = n_epc; m_exl = n_exl;
    end
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir_we", 32'(ir_we), 32'd1);
    chk("rst_pc_we", 32'(pc_we), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_epc", 32'(epc), 32'd0);
    adv();
    rst = 1'b1;

    // 1: R then BEQ
    cls = 3'd0;
    @(negedge clk); chk("t1_if", 32'(state), 32'd0);
    adv(); adv(); adv();
    @(negedge clk);
    chk("t1_wb_state", 32'(state), 32'd4);
    chk("t1_wb_pc_we", 32'(pc_we), 32'd1);
    chk("t1_wb_sel", 32'(npc_sel), 32'd0);
    adv(); cls = 3'd3;
    adv(); adv();
    @(negedge clk);
    chk("t1_ex_state", 32'(state), 32'd2);
    chk("t1_ex_pc_we", 32'(pc_we), 32'd1);
    chk("t1_ex_sel", 32'(npc_sel), 32'd1);
    adv();

    // 2: LW with 3 wait cycles
    cls = 3'd1; mem_ready = 1'b0;
    repeat (6) adv();
    mem_ready = 1'b1;
    @(negedge clk); chk("t2_mem4", 32'(state), 32'd3);
    adv(); mem_ready = 1'b0;
    @(negedge clk);
    chk("t2_wb_state", 32'(state), 32'd4);
    chk("t2_wb_reg_we", 32'(reg_we), 32'd1);
    chk("t2_wb_pc_we", 32'(pc_we), 32'd1);
    adv();

    // 3: SW never ready -> bus error on 16th MEM cycle
    cls = 3'd2;
    repeat (18) adv();
    @(negedge clk);
    chk("t3_state", 32'(state), 32'd3);
    chk("t3_bus_err", 32'(bus_err), 32'd1);
    chk("t3_pc_we", 32'(pc_we), 32'd1);
    adv();
    @(negedge clk);
    chk("t3_if", 32'(state), 32'd0);
    chk("t3_bus_err_off", 32'(bus_err), 32'd0);

    // 4: interrupt at BEQ boundary
    cls = 3'd3; irq = 1'b1; ie = 1'b1; npc_in = 30'h0010_0040;
    adv(); adv();
    @(negedge clk); chk("t4_ex_pc_we", 32'(pc_we), 32'd0);
    adv();
    @(negedge clk);
    chk("t4_int_state", 32'(state), 32'd5);
    chk("t4_int_sel", 32'(npc_sel), 32'd4);
    chk("t4_int_pc_we", 32'(pc_we), 32'd1);
    chk("t4_epc", 32'(epc), 32'h0010_0040);
    adv();
    @(negedge clk); chk("t4_exl", 32'(exl), 32'd1);

    // 5: ERET with irq held, then R diverts to INT
    cls = 3'd7;
    adv();
    @(negedge clk);
    chk("t5_id_sel", 32'(npc_sel), 32'd5);
    chk("t5_id_pc_we", 32'(pc_we), 32'd1);
    adv();
    @(negedge clk);
    chk("t5_exl_clr", 32'(exl), 32'd0);
    chk("t5_no_int", 32'(state), 32'd0);
    cls = 3'd0; npc_in = 30'h0000_1234;
    adv(); adv(); adv();
    @(negedge clk); chk("t5_wb_pc_we", 32'(pc_we), 32'd0);
    adv();
    @(negedge clk);
    chk("t5_int", 32'(state), 32'd5);
    chk("t5_epc", 32'(epc), 32'h0000_1234);
    adv();

    // 6: reset in MEM of LW, then ie=0 blocks the interrupt
    cls = 3'd1; irq = 1'b0; mem_ready = 1'b0;
    adv(); adv(); adv();
    #2 rst = 1'b0;
    #1;
    chk("t6_state", 32'(state), 32'd0);
    chk("t6_exl", 32'(exl), 32'd0);
    chk("t6_epc", 32'(epc), 32'd0);
    adv();
    rst = 1'b1; ie = 1'b0; irq = 1'b1; cls = 3'd0;
    adv(); adv(); adv();
    @(negedge clk);
    chk("t6_wb_pc_we", 32'(pc_we), 32'd1);
    chk("t6_wb_sel", 32'(npc_sel), 32'd0);
    adv();
    @(negedge clk); chk("t6_if", 32'(state), 32'd0);

    // random traffic; class only changes at an instruction fetch
    slow = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      adv();
      rst = ($urandom % 500) != 0;
      if (!m_int && m_pos == 0) begin
        cls  = 3'($urandom % 8);
        slow = ($urandom % 4) == 0;
      end
      irq       = ($urandom % 4) == 0;
      ie        = ($urandom % 4) != 0;
      npc_in    = 30'($urandom);
      mem_ready = slow ? (($urandom % 24) == 0) : (($urandom % 2) == 0);
    end
    adv();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
